muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide instructions. It accepts an M-extension operation from the execute stage and runs a radix-2 shift-add multiply or a restoring divide over a fixed number of cycles. While it works, it holds the pipeline stalled through `busy_o`, then returns a one-cycle result pulse. It sits beside the main ALU. The control unit steers R-type instructions with funct7 = 0000001 here instead of to the ALU.

---
 rtl/muldiv_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit beside the main ALU.
// Runs a radix-2 shift-add multiply or a restoring divide, one bit per cycle,
// stalling the pipeline through busy_o and returning a one-cycle done_o pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start_i   operation request, sampled only in IDLE
//   funct3_i  M-extension funct3 (MUL..REMU)
//   op_a_i    rs1 value (multiplicand / dividend)
//   op_b_i    rs2 value (multiplier / divisor)
//   kill_i    pipeline flush, aborts any operation
//   busy_o    stall request, high from accept through the done_o cycle
//   done_o    one-cycle result-valid pulse
//   result_o  result, held until the next done_o
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3;
  logic            neg_q;    // negate product / quotient in DONE
  logic            neg_r;    // negate remainder in DONE
  logic [PW-1:0]   acc;      // multiply: {partial, multiplier}; divide: [XLEN-1:0] dividend->quotient
  logic [XLEN-1:0] opnd;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] rem;      // partial remainder

  // Accept-time decode: signedness, magnitudes and divide special cases
  logic            is_div_in;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;

  always_comb begin
    is_div_in = funct3_i[2];
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    if (is_div_in) begin
      a_signed = ~funct3_i[0];
      b_signed = ~funct3_i[0];
    end else begin
      a_signed = (funct3_i[1:0] != 2'b11);
      b_signed = ~funct3_i[1];
    end
    a_neg    = a_signed & op_a_i[XLEN-1];
    b_neg    = b_signed & op_b_i[XLEN-1];
    a_mag    = a_neg ? (~op_a_i + XLEN'(1)) : op_a_i;
    b_mag    = b_neg ? (~op_b_i + XLEN'(1)) : op_b_i;
    div_zero = is_div_in & (op_b_i == '0);
    div_ovf  = is_div_in & ~funct3_i[0] & (op_a_i == SMIN) & (op_b_i == ONES);
  end

  // One iteration step for each algorithm; the 33-bit difference carries the borrow
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] rem_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {rem, acc[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd};
  end

  // Sign fix-up and result selection, consumed in DONE
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  always_comb begin
    prod_fix = neg_q ? (~acc + PW'(1)) : acc;
    quo_fix  = neg_q ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_fix  = neg_r ? (~rem + XLEN'(1)) : rem;
    if (f3[2]) begin
      final_res = f3[1] ? rem_fix : quo_fix;
    end else begin
      final_res = (f3[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
    end
  end

  // Sequencer FSM with registered outputs; kill_i overrides every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      f3       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      rem      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (kill_i) begin
        state  <= S_IDLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // busy_o stays up through the done_o cycle and drops here
            busy_o <= 1'b0;
            if (start_i) begin
              busy_o <= 1'b1;
              f3     <= funct3_i;
              cnt    <= '0;
              rem    <= '0;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= 1'b0;
              state  <= S_CALC;
              if (is_div_in) begin
                acc   <= {{XLEN{1'b0}}, a_mag};
                opnd  <= b_mag;
                neg_r <= a_neg;
                // Special cases preload the final quotient/remainder unsigned
                if (div_zero) begin
                  acc   <= {{XLEN{1'b0}}, ONES};
                  rem   <= op_a_i;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= S_DONE;
                end else if (div_ovf) begin
                  acc   <= {{XLEN{1'b0}}, SMIN};
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= S_DONE;
                end
              end else begin
                acc  <= {{XLEN{1'b0}}, b_mag};
                opnd <= a_mag;
              end
            end
          end

          S_CALC: begin
            if (f3[2]) begin
              // Restoring step: keep the difference only when it did not borrow
              if (!rem_diff[XLEN]) begin
                rem               <= rem_diff[XLEN-1:0];
                acc[XLEN-1:0]     <= {acc[XLEN-2:0], 1'b1};
              end else begin
                rem               <= rem_sh[XLEN-1:0];
                acc[XLEN-1:0]     <= {acc[XLEN-2:0], 1'b0};
              end
            end else begin
              // Shift-add step on the multiplier bit at acc[0]
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              state <= S_DONE;
            end
          end

          S_DONE: begin
            result_o <= final_res;
            done_o   <= 1'b1;
            state    <= S_IDLE;
          end

          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed self-checking bench for
// muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_vec;
  int          n_err;
  logic [31:0] last_res;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .kill_i   (kill),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics written with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] za, zb, up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    za = {32'd0, a};
    zb = {32'd0, b};
    ua = longint'(za);
    ub = longint'(zb);
    up = za * zb;
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: r = up[63:32];
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == SMIN && b == 32'hFFFF_FFFF) r = SMIN;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == SMIN && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == SMIN && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = SMIN;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Present a request; called between clock edges
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
  endtask

  // Accept on the next edge, then follow the operation to done_o
  task automatic wait_done(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input bit perturb);
    logic [31:0] exp;
    int          lat;
    int          exp_lat;
    int          busy_n;
    bit          seen;
    exp     = ref_model(f, a, b);
    exp_lat = exp_latency(f, a, b);
    @(posedge clk); #1;
    check_eq({tag, "_busy_acc"}, 32'(busy), 32'd1);
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
      if (perturb && exp_lat > 1) begin
        if (lat == 5) begin
          start  = 1'b0;
          op_a   = $urandom;
          op_b   = $urandom;
          funct3 = 3'($urandom);
        end
        if (lat == 6) start = 1'b1;
        if (lat == 9) begin
          funct3 = f;
          op_a   = a;
          op_b   = b;
        end
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_busy"}, 32'(busy_n), 32'(lat));
    last_res = exp;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
    check_eq({tag, "_hold"}, result, last_res);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b);
    start_op(f, a, b);
    wait_done(tag, f, a, b, 1'b0);
    idle_check(tag);
  endtask

  initial begin
    int dn;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    n_vec    = 0;
    n_err    = 0;
    last_res = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    kill     = 1'b0;
    funct3   = '0;
    op_a     = '0;
    op_b     = '0;

    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_res", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;

    // Directed cases
    run("mul_neg",   3'd0, 32'd7, 32'hFFFF_FFFD);
    run("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2);
    run("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2);
    run("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2);
    run("divu",      3'd5, 32'd100, 32'd7);
    run("remu",      3'd7, 32'd100, 32'd7);
    run("div_z",     3'd4, 32'd5, 32'd0);
    run("rem_z",     3'd6, 32'd5, 32'd0);
    run("divu_z",    3'd5, 32'hDEAD_BEEF, 32'd0);
    run("div_ovf",   3'd4, SMIN, 32'hFFFF_FFFF);
    run("rem_ovf",   3'd6, SMIN, 32'hFFFF_FFFF);

    // Kill mid-divide
    start_op(3'd4, 32'd1000, 32'd7);
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    kill  = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq("kill_busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check_eq("kill_nodone", 32'(dn), 32'd0);
    check_eq("kill_hold", result, last_res);
    run("mul_after_kill", 3'd0, 32'd3, 32'd4);

    // Kill landing on a DONE state
    start_op(3'd4, 32'd5, 32'd0);
    @(posedge clk); #1;
    kill  = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq("kill_done_pulse", 32'(done), 32'd0);
    check_eq("kill_done_busy", 32'(busy), 32'd0);
    check_eq("kill_done_hold", result, last_res);

    // Kill together with start in IDLE
    start_op(3'd0, 32'd9, 32'd9);
    kill = 1'b1;
    @(posedge clk); #1;
    kill  = 1'b0;
    start = 1'b0;
    check_eq("kill_start_busy", 32'(busy), 32'd0);
    idle_check("kill_start");

    // New request while busy must be ignored
    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done("restart_ign", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    idle_check("restart_ign");

    // Back-to-back: next request accepted right after the done_o cycle
    start_op(3'd5, 32'hFFFF_FFF0, 32'd3);
    wait_done("b2b_0", 3'd5, 32'hFFFF_FFF0, 32'd3, 1'b0);
    start_op(3'd0, 32'h0001_0001, 32'h0001_0001);
    wait_done("b2b_1", 3'd0, 32'h0001_0001, 32'h0001_0001, 1'b0);
    idle_check("b2b");

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = pick();
      rb = pick();
      start_op(rf, ra, rb);
      wait_done($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i));
    end
    idle_check("rnd_end");

    // Asynchronous reset mid-CALC
    start_op(3'd0, 32'd11, 32'd13);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_res", result, 32'd0);
    start    = 1'b0;
    last_res = '0;
    @(negedge clk) rst_n = 1'b1;
    idle_check("post_rst");
    run("post_rst_mul", 3'd0, 32'd6, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
